// File: rtl/i2c_cfg_seq_pkg.sv
// Shared types and codec table constants for the I2C configuration sequencer.
// A board variant changes only the register/data constants below.
package i2c_cfg_seq_pkg;

  localparam int WORD_W = 24;

  localparam logic [7:0] CODEC_SLAVE_ADDR = 8'h34;

  localparam logic [7:0] REG_LLIN   = 8'h00;
  localparam logic [7:0] REG_RLIN   = 8'h02;
  localparam logic [7:0] REG_LHP    = 8'h04;
  localparam logic [7:0] REG_RHP    = 8'h06;
  localparam logic [7:0] REG_APATH  = 8'h08;
  localparam logic [7:0] REG_DPATH  = 8'h0A;
  localparam logic [7:0] REG_PWR    = 8'h0C;
  localparam logic [7:0] REG_IFACE  = 8'h0E;
  localparam logic [7:0] REG_ACTIVE = 8'h12;
  localparam logic [7:0] REG_RESET  = 8'h1E;

  localparam logic [7:0] DAT_RESET  = 8'h00;
  localparam logic [7:0] DAT_PWR    = 8'h10;
  localparam logic [7:0] DAT_LIN    = 8'h17;
  localparam logic [7:0] DAT_HP     = 8'h79;
  localparam logic [7:0] DAT_APATH  = 8'h12;
  localparam logic [7:0] DAT_DPATH  = 8'h00;
  localparam logic [7:0] DAT_IFACE  = 8'h02;
  localparam logic [7:0] DAT_ACTIVE = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    XFER,
    GAP,
    CHECK,
    DONE,
    FAIL
  } state_e;

  function automatic logic [WORD_W-1:0] cfg_word(input logic [7:0] reg_addr,
                                                 input logic [7:0] reg_data);
    return {CODEC_SLAVE_ADDR, reg_addr, reg_data};
  endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// Combinational codec configuration table: index -> {slave, reg, data}.
// Entries at or beyond NUM_WORDS read as zero.
module i2c_cfg_rom
  import i2c_cfg_seq_pkg::*;
#(
  parameter int NUM_WORDS = 10
) (
  input  logic [5:0]        idx_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    if (int'(idx_i) < NUM_WORDS) begin
      case (idx_i)
        6'd0:    word_o = cfg_word(REG_RESET,  DAT_RESET);
        6'd1:    word_o = cfg_word(REG_PWR,    DAT_PWR);
        6'd2:    word_o = cfg_word(REG_LLIN,   DAT_LIN);
        6'd3:    word_o = cfg_word(REG_RLIN,   DAT_LIN);
        6'd4:    word_o = cfg_word(REG_LHP,    DAT_HP);
        6'd5:    word_o = cfg_word(REG_RHP,    DAT_HP);
        6'd6:    word_o = cfg_word(REG_APATH,  DAT_APATH);
        6'd7:    word_o = cfg_word(REG_DPATH,  DAT_DPATH);
        6'd8:    word_o = cfg_word(REG_IFACE,  DAT_IFACE);
        6'd9:    word_o = cfg_word(REG_ACTIVE, DAT_ACTIVE);
        default: word_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cfg_seq.sv
// Walks the codec table through the I2C engine one word at a time, retrying
// NACKed words and leaving a bus-free gap between transactions.
module i2c_cfg_seq
  import i2c_cfg_seq_pkg::*;
#(
  parameter int NUM_WORDS  = 10,
  parameter int MAX_RETRY  = 3,
  parameter int GAP_CYCLES = 4,
  parameter int AUTO_START = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [WORD_W-1:0] i2c_data,
  output logic              i2c_go,
  input  logic              i2c_done,
  input  logic              i2c_ack,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [5:0]        word_idx,
  output logic [3:0]        retry_cnt
);

  localparam logic [5:0] LAST_IDX  = 6'(NUM_WORDS - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  state_e     state_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [5:0] word_idx_q;
  logic [3:0] retry_q;
  logic       armed_q;
  logic       nack_q;
  logic [7:0] gap_q;
  logic       start_run_d;

  // IDLE is only ever entered through reset, so AUTO_START launches exactly once.
  always_comb begin
    start_run_d = 1'b0;
    case (state_q)
      IDLE:       start_run_d = start || (AUTO_START != 0);
      DONE, FAIL: start_run_d = start;
      default:    start_run_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      word_idx_q <= '0;
      retry_q    <= '0;
      armed_q    <= 1'b0;
      nack_q     <= 1'b0;
      gap_q      <= '0;
    end else if (start_run_d) begin
      state_q    <= LOAD;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      word_idx_q <= '0;
      retry_q    <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          armed_q <= 1'b0;
          state_q <= XFER;
        end
        // done is only trusted once it has been seen low during this transfer
        XFER: begin
          if (armed_q && i2c_done) begin
            nack_q  <= i2c_ack;
            gap_q   <= '0;
            state_q <= GAP;
          end else if (!i2c_done) begin
            armed_q <= 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            state_q <= CHECK;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        CHECK: begin
          if (!nack_q) begin
            if (word_idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              word_idx_q <= word_idx_q + 6'd1;
              retry_q    <= '0;
              armed_q    <= 1'b0;
              state_q    <= XFER;
            end
          end else if (retry_q < RETRY_MAX) begin
            retry_q <= retry_q + 4'd1;
            armed_q <= 1'b0;
            state_q <= XFER;
          end else begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FAIL;
          end
        end
        IDLE, DONE, FAIL: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  // go must drop in the completion cycle itself, or the engine restarts from state 0.
  assign i2c_go    = (state_q == XFER) && !(armed_q && i2c_done);
  assign busy      = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign word_idx  = word_idx_q;
  assign retry_cnt = retry_q;

  i2c_cfg_rom #(
    .NUM_WORDS(NUM_WORDS)
  ) u_rom (
    .idx_i (word_idx_q),
    .word_o(i2c_data)
  );

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Directed bench for i2c_cfg_seq with a cycle-level engine/slave model and a
// transaction scoreboard.
module tb_i2c_cfg_seq;

  localparam logic [23:0] TBL [10] = '{
    24'h341E00, 24'h340C10, 24'h340017, 24'h340217, 24'h340479,
    24'h340679, 24'h340812, 24'h340A00, 24'h340E02, 24'h341201
  };

  typedef struct {
    int          idx;
    logic [23:0] data;
    int          retry;
    bit          nack;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_done;
  logic        i2c_ack;
  logic        busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [5:0]  word_idx;
  logic [3:0]  retry_cnt;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   go_viol = 0;
  int   est = 0;
  bit   pend_nack = 1'b0;
  exp_t sbq[$];

  i2c_cfg_seq #(
    .NUM_WORDS(10), .MAX_RETRY(3), .GAP_CYCLES(4), .AUTO_START(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .i2c_data(i2c_data), .i2c_go(i2c_go),
    .i2c_done(i2c_done), .i2c_ack(i2c_ack),
    .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .word_idx(word_idx), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model: 33 go-high states, done pulses one cycle after the last one.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      est      <= 0;
      i2c_done <= 1'b1;
      i2c_ack  <= 1'b0;
    end else begin
      i2c_done <= 1'b0;
      if (i2c_go) begin
        if (est == 32) begin
          est      <= 0;
          i2c_done <= 1'b1;
          i2c_ack  <= pend_nack;
        end else begin
          est <= est + 1;
        end
      end
    end
  end

  // Scoreboard: compare in the cycle whose closing edge is the engine's data latch.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && i2c_go && i2c_done) go_viol++;
    if (!rst && i2c_go && est == 1) begin
      check("xfer_expected", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("xfer_data", i2c_data, e.data);
        check("xfer_idx", word_idx, e.idx);
        check("xfer_retry", retry_cnt, e.retry);
        pend_nack = e.nack;
      end
    end
  end

  task automatic push(input int w, input int r, input bit n);
    exp_t e;
    e.idx = w; e.data = TBL[w]; e.retry = r; e.nack = n;
    sbq.push_back(e);
  endtask

  // mode 0: all ACK; 1: word 3 NACKed once; 2: word 5 NACKed on every attempt
  task automatic push_run(input int mode, input int nwords);
    for (int w = 0; w < nwords; w++) begin
      if (mode == 1 && w == 3) push(w, 0, 1'b1);
      if (mode == 2 && w == 5) begin
        for (int r = 0; r < 4; r++) push(w, r, 1'b1);
        return;
      end
      push(w, (mode == 1 && w == 3) ? 1 : 0, 1'b0);
    end
  endtask

  task automatic wait_end(input int max, output int at);
    int n = 0;
    while (!(cfg_done || cfg_err) && n < max) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    check("end_timeout", 32'(n < max), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int c0, c1, n;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_idx", word_idx, 0);
    check("rst_retry", retry_cnt, 0);
    check("rst_go", i2c_go, 0);
    check("rst_data", i2c_data, TBL[0]);

    // clean auto-started run and its latency
    push_run(0, 10);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 10);
    check("auto_load", busy, 1);
    c0 = cyc;
    wait_end(2000, c1);
    check("clean_latency", c1 - c0, 391);
    check("clean_done", cfg_done, 1);
    check("clean_err", cfg_err, 0);
    check("clean_busy", busy, 0);
    check("clean_idx", word_idx, 9);
    check("clean_sb_empty", sbq.size(), 0);
    repeat (5) @(negedge clk);
    check("done_hold", cfg_done, 1);

    // single NACK on word 3, plus a stray start during XFER
    push_run(1, 10);
    pulse_start();
    check("r1_load_done_clr", cfg_done, 0);
    check("r1_load_busy", busy, 1);
    n = 0;
    while (!(word_idx == 6'd1 && i2c_go) && n < 500) begin @(negedge clk); n++; end
    pulse_start();
    check("r1_start_ign_idx", word_idx, 1);
    check("r1_start_ign_busy", busy, 1);
    wait_end(3000, c1);
    check("r1_done", cfg_done, 1);
    check("r1_err", cfg_err, 0);
    check("r1_sb_empty", sbq.size(), 0);

    // word 5 NACKed forever -> FAIL after four attempts
    push_run(2, 10);
    pulse_start();
    wait_end(3000, c1);
    check("f_err", cfg_err, 1);
    check("f_done", cfg_done, 0);
    check("f_idx", word_idx, 5);
    check("f_retry", retry_cnt, 3);
    check("f_busy", busy, 0);
    repeat (100) @(negedge clk);
    check("f_hold_err", cfg_err, 1);
    check("f_sb_empty", sbq.size(), 0);

    // restart from FAIL
    push_run(0, 10);
    pulse_start();
    check("rf_err_clr", cfg_err, 0);
    check("rf_busy", busy, 1);
    check("rf_idx", word_idx, 0);
    wait_end(2000, c1);
    check("rf_done", cfg_done, 1);
    check("rf_sb_empty", sbq.size(), 0);

    // start held high: back-to-back runs
    push_run(0, 10);
    push_run(0, 10);
    start = 1'b1;
    @(negedge clk);
    check("hold_load1", cfg_done, 0);
    wait_end(2000, c1);
    check("hold_done1", cfg_done, 1);
    @(negedge clk);
    check("hold_relaunch_done", cfg_done, 0);
    check("hold_relaunch_busy", busy, 1);
    check("hold_relaunch_idx", word_idx, 0);
    wait_end(2000, c1);
    start = 1'b0;
    check("hold_done2", cfg_done, 1);
    repeat (3) @(negedge clk);
    check("hold_stays_done", cfg_done, 1);
    check("hold_sb_empty", sbq.size(), 0);

    // async reset at engine state 15 of word 2
    push_run(0, 3);
    push_run(0, 10);
    pulse_start();
    n = 0;
    while (!(word_idx == 6'd2 && est == 15) && n < 500) begin @(negedge clk); n++; end
    check("mid_reached", 32'(n < 500), 1);
    rst = 1'b1;
    #1;
    check("mid_go", i2c_go, 0);
    check("mid_busy", busy, 0);
    check("mid_idx", word_idx, 0);
    check("mid_retry", retry_cnt, 0);
    check("mid_done", cfg_done, 0);
    check("mid_data", i2c_data, TBL[0]);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 10);
    check("mid_restart_idx", word_idx, 0);
    wait_end(2000, c1);
    check("mid_final_done", cfg_done, 1);
    check("mid_final_idx", word_idx, 9);
    check("mid_sb_empty", sbq.size(), 0);

    check("go_on_done_cycles", go_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_seq.md
Name: i2c_cfg_seq

Overview:
- Sequences a fixed table of 24-bit codec configuration words (slave address, register address, data) through the I2C transaction engine, one transaction at a time.
- Retries any word the slave NACKs and inserts a bus-free gap between transactions.
- Reports completion or failure to the top level.
- Sits between the board top level / audio init logic and the I2C transaction engine, and runs on the same clock as that engine.

Parameters:
- NUM_WORDS, 10, number of table entries sent per run (1..64).
- MAX_RETRY, 3, extra attempts allowed per word after a NACK (0..15).
- GAP_CYCLES, 4, idle clk cycles between engine completion and the next go (1..255).
- AUTO_START, 1, if 1 a run begins on the first clk after reset deasserts without needing start.

Ports:
- clk  input  1  engine bit clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled request; starts a run from IDLE, DONE or FAIL.
- i2c_data  output  24  current word {slave_addr[7:0], reg_addr[7:0], reg_data[7:0]}; to engine data.
- i2c_go  output  1  engine go; combinational (see Behaviour).
- i2c_done  input  1  engine done.
- i2c_ack  input  1  engine ack; 1 = at least one NACK in the last transaction.
- busy  output  1  run in progress.
- cfg_done  output  1  last run completed with all words ACKed; sticky until next run.
- cfg_err  output  1  last run aborted on retry exhaustion; sticky until next run.
- word_idx  output  6  index of the word being sent, or the failing word in FAIL.
- retry_cnt  output  4  retries used on the current word.

Behaviour:
- Reset values: state=IDLE, busy=0, cfg_done=0, cfg_err=0, word_idx=0, retry_cnt=0, armed=0, gap counter=0. i2c_go=0 (follows from state). i2c_data = table[0].
- Engine contract:
  - While the engine is idle, i2c_done reads 0 after its first clk.
  - go held high advances the engine one state per clk. The engine latches data on its 2nd clk.
  - i2c_done is high for the single cycle following the final stop state. During that cycle the engine is back at state 0, so go must already be low there or the engine restarts.
- armed flag: cleared on entry to XFER; set when i2c_done is sampled 0 in XFER. It masks the post-reset done=1 from being read as completion.
- i2c_go = (state==XFER) && !(armed && i2c_done). This is combinational so go drops in the completion cycle itself.
- i2c_data = table[word_idx], held stable throughout XFER.
- States:
  - IDLE: busy=0. Go to LOAD if start=1, or on the first cycle after reset when AUTO_START=1.
  - LOAD: word_idx=0, retry_cnt=0, cfg_done=0, cfg_err=0, busy=1. Next state XFER.
  - XFER: wait for armed && i2c_done. On that cycle register the NACK flag nack_q <= i2c_ack, then go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to CHECK.
  - CHECK:
    - nack_q=0 and word_idx==NUM_WORDS-1: go to DONE.
    - nack_q=0 otherwise: word_idx+1, retry_cnt=0, go to XFER.
    - nack_q=1 and retry_cnt<MAX_RETRY: retry_cnt+1, word_idx unchanged, go to XFER.
    - nack_q=1 and retry_cnt==MAX_RETRY: go to FAIL.
  - DONE: cfg_done=1, busy=0. Go to LOAD when start=1.
  - FAIL: cfg_err=1, busy=0, word_idx frozen at the failing entry. Go to LOAD when start=1.
- Boundary conditions:
  - start during a run (LOAD..CHECK) is ignored.
  - start held high in DONE/FAIL restarts once per completed run.
  - cfg_done and cfg_err are never both 1.
  - word_idx never exceeds NUM_WORDS-1. retry_cnt saturates at MAX_RETRY.
  - Asynchronous rst during XFER returns to IDLE immediately and drops go. The engine has its own reset on the same rst net.
  - With MAX_RETRY=0 the first NACK goes to FAIL.
- Latency:
  - Each attempt is 33 engine cycles + 1 completion cycle + GAP_CYCLES + 1 CHECK cycle.
  - A clean run is NUM_WORDS × (35+GAP_CYCLES) + 1 cycles from LOAD to DONE.

Decomposition:
- Shared package:
  - state enum (IDLE, LOAD, XFER, GAP, CHECK, DONE, FAIL).
  - CODEC_SLAVE_ADDR = 8'h34.
  - Codec register address constants and default data values.
  - Word width constant 24.
- Sub-module i2c_cfg_rom: combinational index → 24-bit word lookup built from the package constants, so a board variant swaps only the table. Entries at or beyond NUM_WORDS return 24'h000000.

Test Plan:
- Reset deasserts, AUTO_START=1, slave model always ACKs, NUM_WORDS=10, GAP_CYCLES=4 -> ten transactions in order; i2c_data per transaction equals table[0..9]; cfg_done=1 at cycle 391 after LOAD; cfg_err=0; go never high on a done-high cycle.
- Slave NACKs word 3 once, then ACKs -> word 3 sent twice with identical data; retry_cnt shows 1 during the second attempt and 0 for word 4; run ends with cfg_done=1.
- Slave NACKs word 5 always, MAX_RETRY=3 -> word 5 attempted 4 times; FAIL with cfg_err=1, word_idx=5, retry_cnt=3, busy=0; no transaction for word 6.
- From FAIL, pulse start with slave now ACKing -> cfg_err clears in LOAD; run restarts at word 0; ends with cfg_done=1.
- rst asserted mid-transaction at engine state 15 of word 2 -> outputs at reset values in the same cycle, go=0; after release with AUTO_START=1, the run restarts at word 0.
- start held high continuously with AUTO_START=0 -> back-to-back runs with cfg_done toggling 1→0 at each LOAD; start pulses during XFER have no effect on word_idx.
